// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared state encoding, digit counts and BCD helper for the display path
package display_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] LOAD = 2'd2;

    localparam int BCD_DIGITS      = 4;
    localparam int SCRATCH_DIGITS  = 5;
    localparam int MAX_BCD_DEFAULT = 9999;

    // Elaboration-time conversion of a small integer to packed BCD digits.
    function automatic logic [15:0] bin_to_bcd16(input int unsigned v);
        logic [15:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// rtl/bcd_digit_adjust.sv - double-dabble per-digit add-3-if-at-least-5 correction
module bcd_digit_adjust (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/result_bcd_formatter.sv
// rtl/result_bcd_formatter.sv - captures score/class, converts score to BCD, drives display F/Q
module result_bcd_formatter
    import display_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DISPLAY_HEX = 0,
    parameter int MAX_BCD     = MAX_BCD_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_value,
    input  logic [3:0]       in_class,
    output logic [15:0]      F,
    output logic [3:0]       Q,
    output logic             ovf,
    output logic             busy
);

    localparam int              CW     = $clog2(WIDTH + 1);
    localparam int              SW     = 4 * SCRATCH_DIGITS;
    localparam logic [CW-1:0]   LAST   = CW'(WIDTH);
    localparam logic [15:0]     SAT_F  = bin_to_bcd16(MAX_BCD);
    localparam logic [31:0]     MAX_U  = 32'(MAX_BCD);

    logic [1:0]          state_q, state_d;
    logic [WIDTH-1:0]    shift_q, shift_d;
    logic [SW-1:0]       scratch_q, scratch_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                sat_q, sat_d;
    logic [3:0]          cls_q, cls_d;
    logic [15:0]         f_q, f_d;
    logic [3:0]          q_q, q_d;
    logic                ovf_q, ovf_d;

    logic                xfer;
    logic [SW-1:0]       adj;
    logic [SW+WIDTH-1:0] cat_shifted;

    assign xfer = in_valid && in_ready;

    for (genvar g = 0; g < SCRATCH_DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_i (scratch_q[4*g +: 4]),
            .digit_o (adj[4*g +: 4])
        );
    end

    // Scratch and score shift as one long register so the score MSB feeds the ones digit.
    assign cat_shifted = {adj, shift_q} << 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (xfer) state_d = (DISPLAY_HEX != 0) ? LOAD : CONV;
            CONV:    if (cnt_d == LAST) state_d = LOAD;
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == IDLE) && !rst;
        busy     = (state_q == CONV) || (state_q == LOAD);
    end

    always_comb begin
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        sat_d     = sat_q;
        cls_d     = cls_q;
        f_d       = f_q;
        q_d       = q_q;
        ovf_d     = ovf_q;
        if (xfer) begin
            shift_d   = in_value;
            scratch_d = '0;
            cnt_d     = '0;
            sat_d     = 32'(in_value) > MAX_U;
            cls_d     = in_class;
        end else if (state_q == CONV) begin
            scratch_d = cat_shifted[SW+WIDTH-1:WIDTH];
            shift_d   = cat_shifted[WIDTH-1:0];
            cnt_d     = cnt_q + 1'b1;
        end else if (state_q == LOAD) begin
            if (DISPLAY_HEX != 0) begin
                f_d   = 16'(shift_q);
                ovf_d = 1'b0;
            end else begin
                f_d   = sat_q ? SAT_F : scratch_q[15:0];
                ovf_d = sat_q;
            end
            q_d = cls_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            cls_q     <= 4'd0;
            f_q       <= 16'd0;
            q_q       <= 4'd0;
            ovf_q     <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
            cls_q     <= cls_d;
            f_q       <= f_d;
            q_q       <= q_d;
            ovf_q     <= ovf_d;
        end
    end

    assign F   = f_q;
    assign Q   = q_q;
    assign ovf = ovf_q;

endmodule
